imem_ctrl: RTL and testbench
============================

# imem_ctrl

Access controller for the 256-word instruction memory array. It shares the single memory port between the fetch stage (reads) and the program loader (writes), and arbitrates between them. It registers fetch read data and flags bad addresses. It also holds the core in a boot phase until loading completes.

## Interface
- IDX_W, 8: word-index width; memory depth is 2**IDX_W words
- NOP_INSTR, 32'h00000013: data returned on a faulted fetch
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  registered read response valid
- f_rdata  out  32  registered read data
- f_err  out  1  registered fault flag, qualified by f_rvalid
- l_req  in  1  loader write request
- l_addr  in  32  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader request accepted this cycle (combinational)
- l_done  in  1  single-cycle pulse: load session finished
- l_err  out  1  registered 1-cycle pulse: last granted write was dropped
- cpu_hold  out  1  core must stall fetch/PC
- m_idx  out  IDX_W  memory word index (combinational)
- m_we  out  1  memory write enable (combinational)
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory combinational read data

## Operation
- Address legality: word index = addr[IDX_W+1:2].
- An address is legal iff addr[1:0]==0 and addr[31:IDX_W+2]==0.
- FSM states: BOOT, RUN. Reset enters BOOT when the configuration macro is defined, RUN otherwise.
- BOOT:
  - cpu_hold=1.
  - Only the loader is served: f_gnt=0.
  - l_gnt=l_req.
  - l_done moves the FSM to RUN on the next edge.
- RUN:
  - cpu_hold=0.
  - l_done is ignored.
  - The state stays RUN until reset.
- Arbitration in RUN:
  - Exactly one grant per cycle.
  - A sole requester is always granted.
  - If both request, grant the requester not granted last. The round-robin pointer `last` updates on every grant.
  - The pointer resets to "loader last", so fetch wins the first tie.
- Memory port:
  - m_idx follows the granted requester's index. With no grant it follows f_addr.
  - m_wdata=l_wdata.
  - m_we=l_gnt AND the l_addr is legal.
- Illegal loader write: granted, no memory write, l_err pulses in the next cycle.
- Fetch response, in the cycle after f_gnt:
  - f_rvalid=1.
  - Legal address: f_rdata=m_rdata sampled at the grant edge, f_err=0.
  - Illegal address: f_rdata=NOP_INSTR, f_err=1.
  - Without a grant, f_rvalid=0 and f_rdata/f_err hold their previous values.
- Requesters must hold req/addr/data stable until granted. An ungranted request carries no state.

## Timing
- Grant: same cycle as the request (combinational).
- Write: takes effect at the edge ending the grant cycle.
- Fetch read latency: 1 cycle (grant in N, f_rvalid in N+1). Back-to-back grants give one response per cycle.
- Read-after-write: a fetch granted the cycle after a write to the same index returns the new data. Same-cycle conflicts cannot occur because there is one grant per cycle.
- Reset values:
  - f_rvalid=0, f_rdata=0, f_err=0, l_err=0.
  - Pointer = loader-last.
  - State = BOOT (macro defined) or RUN.
  - cpu_hold=1 (macro defined) or 0.
- Asynchronous reset mid-operation: in-flight responses are discarded and f_rvalid drops immediately.
- l_done in the same cycle as a granted write: the write completes and the state becomes RUN next cycle.

## Configuration
- IMEM_BOOTLOAD_EN defined:
  - The BOOT state and cpu_hold behaviour exist as above.
  - The loader port is live in both states.
- IMEM_BOOTLOAD_EN undefined:
  - There is no BOOT state: the FSM is permanently RUN.
  - cpu_hold=0, l_gnt=0, m_we=0, l_err=0.
  - l_req/l_addr/l_wdata/l_done are ignored.
  - All fetches are granted as sole requester.

## Test plan
- Boot load (macro on): after reset, cpu_hold=1 and f_gnt=0 with f_req=1. Write 0xDEADBEEF to 0x8, then pulse l_done. Next cycle cpu_hold=0. Fetch 0x8 -> f_gnt=1, then next cycle f_rvalid=1, f_rdata=0xDEADBEEF, f_err=0.
- Tie round-robin in RUN: f_req and l_req held high for 4 cycles -> grants go F, L, F, L. Exactly one f_rvalid follows each F grant.
- Bad fetch: f_addr=0x2, then f_addr=0x400 -> both granted; each response has f_rvalid=1, f_err=1, f_rdata=0x00000013.
- Bad write: l_addr=0x1001 -> l_gnt=1, m_we=0, l_err=1 next cycle. A later fetch of index 0 returns unchanged data.
- RAW: write 0x12345678 to 0x40 in cycle N, fetch 0x40 granted in N+1 -> f_rdata=0x12345678 in N+2.
- Reset mid-operation: drop rst_n while f_rvalid=1 -> f_rvalid=0 immediately, cpu_hold=1 (macro on). With the macro off: cpu_hold=0, and l_req=1 gives l_gnt=0.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction memory access controller: shares one memory port between fetch reads and loader writes.
// Build option IMEM_BOOTLOAD_EN enables the BOOT phase and the loader port; otherwise fetch only.
module imem_ctrl #(
    parameter int unsigned IDX_W     = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    output logic             f_err,
    input  logic             l_req,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_gnt,
    input  logic             l_done,
    output logic             l_err,
    output logic             cpu_hold,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_we,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:IDX_W+2] == '0);
    endfunction

    state_e           state_q, state_d;
    logic             last_l_q, last_l_d;
    logic             f_rvalid_q;
    logic [31:0]      f_rdata_q;
    logic             f_err_q;
    logic             l_err_q;
    logic             l_req_eff;
    logic             l_legal;
    logic             f_legal;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] l_idx;
    logic             boot_exit;

    assign f_legal = addr_legal(f_addr);
    assign f_idx   = f_addr[IDX_W+1:2];

`ifdef IMEM_BOOTLOAD_EN
    localparam state_e RESET_STATE = ST_BOOT;
    assign l_req_eff = l_req;
    assign l_legal   = addr_legal(l_addr);
    assign l_idx     = l_addr[IDX_W+1:2];
    assign boot_exit = l_done;
`else
    // Loader port is dead: only its data lane still reaches m_wdata.
    localparam state_e RESET_STATE = ST_RUN;
    logic unused_loader;
    assign unused_loader = ^{l_req, l_addr, l_done};
    assign l_req_eff = 1'b0;
    assign l_legal   = 1'b0;
    assign l_idx     = '0;
    assign boot_exit = 1'b1;
`endif

    // last_l_q=1 means the loader won most recently, so fetch wins the next tie.
    always_comb begin
        state_d  = state_q;
        last_l_d = last_l_q;
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;
        cpu_hold = 1'b0;
        case (state_q)
            ST_BOOT: begin
                cpu_hold = 1'b1;
                l_gnt    = l_req_eff;
                if (boot_exit) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (f_req && l_req_eff) begin
                    f_gnt = last_l_q;
                    l_gnt = !last_l_q;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req_eff;
                end
            end
        endcase
        if (l_gnt) begin
            last_l_d = 1'b1;
        end else if (f_gnt) begin
            last_l_d = 1'b0;
        end
    end

    assign m_idx   = l_gnt ? l_idx : f_idx;
    assign m_we    = l_gnt && l_legal;
    assign m_wdata = l_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            last_l_q   <= 1'b1;
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            f_err_q    <= 1'b0;
            l_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_l_q   <= last_l_d;
            f_rvalid_q <= f_gnt;
            l_err_q    <= l_gnt && !l_legal;
            if (f_gnt) begin
                f_rdata_q <= f_legal ? m_rdata : NOP_INSTR;
                f_err_q   <= !f_legal;
            end
        end
    end

    assign f_rvalid    = f_rvalid_q;
    assign f_rdata     = f_rdata_q;
    assign f_err       = f_err_q;
    assign l_err       = l_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: owns the memory array and predicts every output from the access rules.
module tb_imem_ctrl;
  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_done;
  logic        l_err;
  logic        cpu_hold;
  logic [7:0]  m_idx;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        dbg_state;

`ifdef IMEM_BOOTLOAD_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  imem_ctrl #(.IDX_W(8), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_done(l_done), .l_err(l_err), .cpu_hold(cpu_hold),
    .m_idx(m_idx), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0203);
  endfunction

  // memory array the controller drives
  logic [31:0] mem [256];
  assign m_rdata = mem[m_idx];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (m_we) mem[m_idx] <= m_wdata;
    end
  end

  // reference model and scoreboard
  int          n_checks;
  int          n_fail;
  logic [31:0] ref_mem [256];
  logic        booting;
  logic        loader_last;
  logic [31:0] held_rdata;
  logic        held_err;
  logic [32:0] exp_q[$];

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'd1024);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    booting     = BOOT_EN;
    loader_last = 1'b1;
    held_rdata  = 32'h0;
    held_err    = 1'b0;
    exp_q.delete();
  endtask

  // driver: one clock cycle, starting and ending at a falling edge
  task automatic step(input logic fr, input logic [31:0] fa, input logic lr,
                      input logic [31:0] la, input logic [31:0] lw, input logic ld);
    logic le, gf, gl;
    logic [32:0] e;
    f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = lw; l_done = ld;
    #1;
    le = BOOT_EN && lr;
    if (booting) begin
      gf = 1'b0; gl = le;
    end else if (fr && le) begin
      gf = loader_last; gl = !loader_last;
    end else begin
      gf = fr; gl = le;
    end
    chk("f_gnt", f_gnt, gf);
    chk("l_gnt", l_gnt, gl);
    chk("cpu_hold", cpu_hold, booting);
    chk("m_we", m_we, gl && legal(la));
    chk("m_idx", m_idx, gl ? idx_of(la) : idx_of(fa));
    chk("m_wdata", m_wdata, lw);
    if (gf) begin
      if (legal(fa)) exp_q.push_back({1'b0, ref_mem[idx_of(fa)]});
      else           exp_q.push_back({1'b1, 32'h0000_0013});
    end
    if (gl && legal(la)) ref_mem[idx_of(la)] = lw;
    if (gl) loader_last = 1'b1;
    else if (gf) loader_last = 1'b0;
    @(posedge clk);
    #1;
    if (booting && ld) booting = 1'b0;
    chk("f_rvalid", f_rvalid, gf);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      held_err   = e[32];
      held_rdata = e[31:0];
    end
    chk("f_rdata", f_rdata, held_rdata);
    chk("f_err", f_err, held_err);
    chk("l_err", l_err, gl && !legal(la));
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rand_step();
    logic [31:0] fa, la;
    fa = ($urandom_range(0, 7) == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    la = ($urandom_range(0, 7) == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    step(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)), la, $urandom,
         $urandom_range(0, 15) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_addr = '0;
    l_wdata = '0; l_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_f_err", f_err, 1'b0);
    chk("rst_l_err", l_err, 1'b0);
    chk("rst_cpu_hold", cpu_hold, BOOT_EN);
    rst_n = 1'b1;

`ifdef IMEM_BOOTLOAD_EN
    // boot load, then first fetch of the loaded word
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h8, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("boot_rdata", f_rdata, 32'hDEAD_BEEF);
`else
    step(1'b0, 32'h0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("nowrite_rdata", f_rdata, init_word(2));
`endif

    // tie round-robin
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 4 * i, 1'b1, 32'h80 + 4 * i, $urandom, 1'b0);

    // illegal fetches
    step(1'b1, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("badf_unaligned", f_rdata, 32'h0000_0013);
    step(1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("badf_range", f_err, 1'b1);
    idle();

    // illegal write, then read index 0
    step(1'b0, 32'h0, 1'b1, 32'h1001, 32'hBAD0_BAD0, 1'b0);
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("badw_idx0", f_rdata, init_word(0));

    // read-after-write
    step(1'b0, 32'h0, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
    step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) rand_step();

    // asynchronous reset with a response in flight
    step(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_rvalid", f_rvalid, 1'b1);
    rst_n = 1'b0;
`ifndef IMEM_BOOTLOAD_EN
    l_req = 1'b1;
`endif
    #1;
    chk("arst_f_rvalid", f_rvalid, 1'b0);
    chk("arst_f_rdata", f_rdata, 32'h0);
    chk("arst_cpu_hold", cpu_hold, BOOT_EN);
`ifndef IMEM_BOOTLOAD_EN
    chk("arst_l_gnt", l_gnt, 1'b0);
`endif
    l_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 8; i++) step(1'b1, 4 * i, 1'b1, 32'h200 + 4 * i, $urandom, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 200; i++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
